// File: rtl/parity_pkg.sv
// parity_pkg: frame FSM states and parity helpers shared by the parity transmitter.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Widest word even_par accepts; narrower words are zero-extended by the caller.
  localparam int PAR_MAX_W = 64;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] bits);
    return ^bits;
  endfunction

  function automatic int frame_bits(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/parity_baud_cnt.sv
// parity_baud_cnt: bit-period down-counter; tick is high while the count is zero.
module parity_baud_cnt #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: start / LSB-first data / even parity / stop frame transmitter.
// Define PARITY_TX_ERRINJ_EN to add the par_err_i parity error inject input.
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef PARITY_TX_ERRINJ_EN
  input  logic              par_err_i,
`endif
  output logic              tx_line,
  output logic              busy,
  output logic              done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic [IW-1:0]     bit_idx;
  logic              par;
  logic              par_in;
  logic              tick;
  logic              cnt_load;
  logic              accept;
  logic              last_bit;

  parity_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .tick(tick)
  );

`ifdef PARITY_TX_ERRINJ_EN
  assign par_in = even_par(PAR_MAX_W'(in_data)) ^ par_err_i;
`else
  assign par_in = even_par(PAR_MAX_W'(in_data));
`endif

  assign shift_nxt = shift >> 1;
  assign last_bit  = (bit_idx == LAST_IDX);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_load  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_load = 1'b1;
          if (last_bit) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_load  = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_line carries the level of the state being entered, so it moves with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
      tx_line <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= (state == STOP) && tick;
      case (state)
        IDLE: begin
          if (accept) begin
            shift   <= in_data;
            par     <= par_in;
            bit_idx <= '0;
            tx_line <= 1'b0;
          end
        end
        START: begin
          if (tick) tx_line <= shift[0];
        end
        DATA: begin
          if (tick) begin
            if (last_bit) begin
              tx_line <= par;
            end else begin
              shift   <= shift_nxt;
              bit_idx <= bit_idx + IW'(1);
              tx_line <= shift_nxt[0];
            end
          end
        end
        PARITY: begin
          if (tick) tx_line <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: scoreboard bench; expected frames come from a line-level reference model.
module tb_parity_serial_tx;

  localparam int DW = 8;
  localparam int BD = 4;
  localparam int FB = DW + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] data_a;
  logic          valid_a, ready_a, tx_a, busy_a, done_a;
  logic [0:0]    data_b;
  logic          valid_b, ready_b, tx_b, busy_b, done_b;
`ifdef PARITY_TX_ERRINJ_EN
  logic          err_a;
`endif

  parity_serial_tx #(.DATA_W(DW), .BAUD_DIV(BD)) dut_a (
    .clk(clk), .rst(rst), .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
`ifdef PARITY_TX_ERRINJ_EN
    .par_err_i(err_a),
`endif
    .tx_line(tx_a), .busy(busy_a), .done(done_a)
  );

  parity_serial_tx #(.DATA_W(1), .BAUD_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
`ifdef PARITY_TX_ERRINJ_EN
    .par_err_i(1'b0),
`endif
    .tx_line(tx_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int last_done_cyc = -1;
  bit mon_en = 1'b1;
  bit in_frame = 1'b0;
  int fcyc = 0;
  logic [FB-1:0] cur;
  logic [FB-1:0] exp_q[$];

  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line levels in time order: start, data LSB first, parity, stop.
  function automatic logic [FB-1:0] model_frame(input logic [DW-1:0] d, input logic e);
    logic [FB-1:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
    f[DW+1] = logic'($countones(d) % 2) ^ e;
    f[DW+2] = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else if (mon_en) begin
      if (!in_frame) begin
        if (tx_a === 1'b0) begin
          chk("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            in_frame = 1'b1;
            fcyc = 0;
          end
        end else begin
          chk("idle_done_low", 32'(done_a), 0);
        end
      end
      if (in_frame) begin
        if (fcyc < FB * BD) begin
          chk("tx_bit", 32'(tx_a), 32'(cur[fcyc / BD]));
          chk("busy_in_frame", 32'(busy_a), 1);
          chk("done_early", 32'(done_a), 0);
        end else begin
          chk("done_pulse", 32'(done_a), 1);
          chk("ready_at_done", 32'(ready_a), 1);
          chk("tx_idle_at_done", 32'(tx_a), 1);
          last_done_cyc = cyc_n;
          in_frame = 1'b0;
        end
        fcyc++;
      end
    end
  end

  task automatic send_a(input logic [DW-1:0] d, input logic e, input bit keep,
                        input bit push, output int acc_cyc);
    int n;
    @(negedge clk);
    data_a  = d;
    valid_a = 1'b1;
`ifdef PARITY_TX_ERRINJ_EN
    err_a = e;
`endif
    if (push) exp_q.push_back(model_frame(d, e));
    n = 0;
    while (!ready_a && n < 500) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc_n;
    chk("accept_ready", 32'(ready_a), 1);
    @(posedge clk);
    #1;
    if (!keep) valid_a = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size() != 0 || in_frame), 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, acc;
    logic [DW-1:0] d;
    logic e;
    bit keep;
    logic [3:0] exp4;

    rst = 1'b1; valid_a = 1'b0; data_a = '0; valid_b = 1'b0; data_b = '0;
`ifdef PARITY_TX_ERRINJ_EN
    err_a = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_a), 1);
    chk("rst_ready", 32'(ready_a), 1);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_tx_b", 32'(tx_b), 1);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx_a), 1);
      chk("idle_ready", 32'(ready_a), 1);
      chk("idle_busy", 32'(busy_a), 0);
      chk("idle_done", 32'(done_a), 0);
    end

    send_a(8'hA5, 1'b0, 1'b0, 1'b1, acc);
    wait_idle();

    send_a(8'h07, 1'b0, 1'b1, 1'b1, acc1);
    send_a(8'h00, 1'b0, 1'b0, 1'b1, acc2);
    chk("b2b_accept_after_done", 32'(acc2), 32'(last_done_cyc));
    wait_idle();

    // Abandon a frame of 0xFF during its third data bit.
    mon_en = 1'b0;
    send_a(8'hFF, 1'b0, 1'b0, 1'b0, acc);
    repeat (14) @(negedge clk);
    chk("mid_frame_busy", 32'(busy_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx_a), 1);
    chk("rst_mid_busy", 32'(busy_a), 0);
    chk("rst_mid_ready", 32'(ready_a), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done_a), 0);
      chk("idle_after_abort", 32'(tx_a), 1);
    end
    mon_en = 1'b1;
    send_a(8'h01, 1'b0, 1'b0, 1'b1, acc);
    wait_idle();

`ifdef PARITY_TX_ERRINJ_EN
    send_a(8'hA5, 1'b1, 1'b0, 1'b1, acc);
    repeat (37) @(negedge clk);
    chk("errinj_parity_odd", 32'(($countones(8'hA5) + int'(tx_a)) % 2), 1);
    wait_idle();
    err_a = 1'b0;
`endif

    for (int i = 0; i < 12; i++) begin
      d = DW'($urandom);
      keep = (i != 11) && ($urandom_range(0, 1) == 1);
      e = 1'b0;
`ifdef PARITY_TX_ERRINJ_EN
      e = 1'($urandom_range(0, 1));
`endif
      send_a(d, e, keep, 1'b1, acc);
      if (!keep) repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle();

    for (int v = 1; v >= 0; v--) begin
      @(negedge clk);
      data_b = 1'(v);
      valid_b = 1'b1;
      chk("b_ready", 32'(ready_b), 1);
      @(posedge clk);
      #1 valid_b = 1'b0;
      exp4 = {1'b1, 1'($countones(1'(v)) % 2), 1'(v), 1'b0};
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("b_tx", 32'(tx_b), 32'(exp4[k]));
        chk("b_busy", 32'(busy_b), 1);
      end
      @(negedge clk);
      chk("b_done", 32'(done_b), 1);
      chk("b_tx_idle", 32'(tx_b), 1);
    end

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
